// File: rtl/csa_err_monitor.sv
// csa_err_monitor: error-metric monitor for approximate adders.
// Accepts operand/result tuples, recomputes the exact sum and accumulates
// error count, maximum error distance and summed error distance over a
// programmed number of samples. Pipeline: S1 capture, S2 error distance,
// S3 accumulate.
module csa_err_monitor #(
  parameter int ADDER_SIZE = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           START,
  input  logic [CNT_WIDTH-1:0]           NUM_SAMPLES,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [ADDER_SIZE:1]            A,
  input  logic [ADDER_SIZE:1]            B,
  input  logic                           CIN,
  input  logic [ADDER_SIZE:1]            SUM,
  input  logic                           COUT,
  output logic                           BUSY,
  output logic                           DONE,
  output logic [CNT_WIDTH-1:0]           SAMPLE_COUNT,
  output logic [CNT_WIDTH-1:0]           ERR_COUNT,
  output logic [ADDER_SIZE:0]            MAX_ED,
  output logic [ADDER_SIZE+CNT_WIDTH:0]  SUM_ED
);

  localparam int STAGES = 2;
  localparam int RW     = ADDER_SIZE + 1;
  localparam int SW     = ADDER_SIZE + CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Run bookkeeping
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic                 accept;
  logic                 start_ok;
  logic                 last_accept;

  // Pipeline valid bits: [1] = S1 tuple held, [2] = S2 error distance held
  logic [STAGES:1]      vld_pipe;

  // S1 tuple registers
  logic [ADDER_SIZE:1]  s1_a;
  logic [ADDER_SIZE:1]  s1_b;
  logic                 s1_cin;
  logic [RW-1:0]        s1_r;

  // S2 error distance
  logic [RW-1:0]        exact_c;
  logic [RW-1:0]        ed_c;
  logic [RW-1:0]        s2_ed;

  // Accumulators
  logic [CNT_WIDTH-1:0] sample_cnt_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;
  logic [RW-1:0]        max_ed_q;
  logic [SW-1:0]        sum_ed_q;

  assign accept      = IN_VALID & IN_READY;
  // START only counts when no run is in flight
  assign start_ok    = START & ((state == ST_IDLE) | (state == ST_DONE));
  assign last_accept = accept & ((acc_cnt + CNT_WIDTH'(1)) == target);

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) state_nxt = (NUM_SAMPLES == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_accept) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Once S1 is empty, the sample still in S2 is absorbed at this very
        // edge, so both valid bits are clear and the final totals land
        // together with DONE.
        if (!vld_pipe[1]) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    IN_READY = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      ST_RUN:   begin IN_READY = 1'b1; BUSY = 1'b1; end
      ST_DRAIN: BUSY = 1'b1;
      ST_DONE:  DONE = 1'b1;
      default:  ;
    endcase
  end

  // Latch sample target on START and count accepted tuples
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      target  <= '0;
      acc_cnt <= '0;
    end else if (start_ok) begin
      target  <= NUM_SAMPLES;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_WIDTH'(1);
    end
  end

  // S1: capture the tuple on acceptance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe[1] <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_cin      <= 1'b0;
      s1_r        <= '0;
    end else begin
      vld_pipe[1] <= accept;
      if (accept) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_cin <= CIN;
        s1_r   <= {COUT, SUM};
      end
    end
  end

  // Exact sum and absolute error distance from the S1 tuple
  always_comb begin
    exact_c = {1'b0, s1_a} + {1'b0, s1_b} + {{ADDER_SIZE{1'b0}}, s1_cin};
    ed_c    = (exact_c >= s1_r) ? (exact_c - s1_r) : (s1_r - exact_c);
  end

  // S2: register the error distance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe[2] <= 1'b0;
      s2_ed       <= '0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) s2_ed <= ed_c;
    end
  end

  // S3: accumulate statistics; a new run clears them first. The pipeline
  // is empty whenever START is honoured, so the clear never drops a sample.
  // Widths are sized so nothing can wrap within one run.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
    end else if (start_ok) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
    end else if (vld_pipe[2]) begin
      sample_cnt_q <= sample_cnt_q + CNT_WIDTH'(1);
      err_cnt_q    <= err_cnt_q + CNT_WIDTH'(s2_ed != '0);
      if (s2_ed > max_ed_q) max_ed_q <= s2_ed;
      sum_ed_q     <= sum_ed_q + {{CNT_WIDTH{1'b0}}, s2_ed};
    end
  end

  assign SAMPLE_COUNT = sample_cnt_q;
  assign ERR_COUNT    = err_cnt_q;
  assign MAX_ED       = max_ed_q;
  assign SUM_ED       = sum_ed_q;

endmodule

// File: doc/csa_err_monitor.md
# csa_err_monitor

Sequential error-metric monitor for the approximate adder family (carry-skip and relatives). It sits at the response end of the adder test harness: it samples operand/result tuples, computes the exact sum internally, and accumulates error statistics over a programmed number of samples. The results are the error count, the maximum error distance and the summed error distance. This is the same data the stimulus side exercises, reduced to figures of merit for hardware characterisation.

## Interface

Parameters:
- ADDER_SIZE, 8, operand width of the adder under test.
- CNT_WIDTH, 16, width of the sample target and counters.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse; begins a measurement run.
- NUM_SAMPLES  input  CNT_WIDTH  number of samples in the run; latched on accepted START.
- IN_VALID  input  1  sample tuple on A/B/CIN/SUM/COUT is valid.
- IN_READY  output  1  monitor accepts a sample this cycle.
- A, B  input  [ADDER_SIZE:1]  operands applied to the adder under test.
- CIN  input  1  carry-in applied.
- SUM  input  [ADDER_SIZE:1]  adder-under-test sum.
- COUT  input  1  adder-under-test carry-out.
- BUSY  output  1  run in progress (RUN or DRAIN).
- DONE  output  1  results valid and held.
- SAMPLE_COUNT  output  CNT_WIDTH  samples accumulated.
- ERR_COUNT  output  CNT_WIDTH  samples with nonzero error distance.
- MAX_ED  output  ADDER_SIZE+1  largest error distance seen.
- SUM_ED  output  ADDER_SIZE+CNT_WIDTH+1  sum of error distances.

## Operation

- Exact result: E = A + B + CIN, ADDER_SIZE+1 bits, unsigned, no overflow.
- Approximate result: R = {COUT, SUM}, ADDER_SIZE+1 bits.
- Error distance: ED = |E − R|, unsigned, ADDER_SIZE+1 bits.
- Pipeline:
  - S1 registers the tuple on acceptance (IN_VALID & IN_READY).
  - S2 registers ED plus a valid bit.
  - S3 updates the accumulators:
    - SAMPLE_COUNT += 1.
    - ERR_COUNT += (ED != 0).
    - MAX_ED = max(MAX_ED, ED).
    - SUM_ED += ED.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE: IN_READY=0. START clears all accumulators and latches NUM_SAMPLES. Next state is RUN, or DONE if NUM_SAMPLES==0.
  - RUN: IN_READY=1. An internal accepted-count increments on each acceptance. The acceptance that makes accepted-count equal the target moves the FSM to DRAIN.
  - DRAIN: IN_READY=0. Stays until the S1/S2 valid bits are both clear, then goes to DONE.
  - DONE: DONE=1, outputs held. START behaves as in IDLE and restarts the run.
- START during RUN or DRAIN is ignored.
- IN_VALID outside RUN is ignored; no sample is captured.
- Counters never wrap. ERR_COUNT and SAMPLE_COUNT are bounded by NUM_SAMPLES, and the SUM_ED width covers the worst case.

## Timing

- Reset (RST_N low, any state, including mid-run):
  - FSM goes to IDLE and pipeline valid bits clear.
  - IN_READY=0, BUSY=0, DONE=0.
  - SAMPLE_COUNT=0, ERR_COUNT=0, MAX_ED=0, SUM_ED=0.
  - Nothing resumes on release.
- START is sampled at edge t0. At edge t0, BUSY=1 and IN_READY=1 become visible (RUN), and the accumulators read 0.
- Sample accepted at edge t: its contribution is visible on the accumulator outputs after edge t+2. Latency is 2 cycles; throughput is 1 sample/cycle.
- Last sample accepted at edge t: IN_READY=0 after edge t. DONE=1 and BUSY=0 after edge t+2, in the same cycle the final accumulator values appear.
- NUM_SAMPLES==0: DONE=1 after the START edge; all accumulators are 0.
- IN_VALID gaps in RUN: no acceptance and no accumulator change; the run simply extends.
- START concurrent with DONE state: accumulators clear and DONE drops at the same edge.

## Test plan

Scenarios assume ADDER_SIZE=8.

1. Exact adder, NUM_SAMPLES=3, tuples (A=E0,B=0F,CIN=0,R=0EF), (E0,0F,1,R=0F0), (00,00,0,R=000) -> DONE 2 cycles after the last accept; SAMPLE_COUNT=3, ERR_COUNT=0, MAX_ED=0, SUM_ED=0.
2. Injected sum error, NUM_SAMPLES=2: (E0,0F,0, SUM=EB,COUT=0), then (F0,10,1, SUM=01,COUT=0) -> E=0EF/ED=4, then E=101/ED=0x100. Result ERR_COUNT=2, MAX_ED=0x100, SUM_ED=0x104.
3. Back-to-back versus gapped IN_VALID (valid 1,0,0,1,1), NUM_SAMPLES=3 -> exactly 3 accepts, IN_READY falls after the third. IN_VALID held high after that is not counted (SAMPLE_COUNT=3).
4. NUM_SAMPLES=0 -> DONE=1 the cycle after START, BUSY never 1, all counters 0.
5. RST_N pulsed low mid-run after 2 of 5 samples -> all outputs 0 immediately (asynchronously). After release the monitor sits in IDLE with IN_READY=0 until a new START.
6. START pulsed during RUN -> ignored, run completes with the original NUM_SAMPLES. START in DONE -> accumulators clear, new run proceeds.
